mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage of the pipelined RISC-V core, sitting between the execute/memory pipeline register and the memory/writeback register. It passes ALU results through for non-memory instructions. For loads and stores it runs a single-outstanding request/acknowledge transaction on the data-memory bus, stalling the upstream pipeline until the access completes. It also produces the rd address, rd value, writeback enable and writeback-from-memory flag consumed by the memory/writeback register.

## Interface
- TIMEOUT_CYCLES, 255: REQ-state cycles without ack before abort (only with MEM_TIMEOUT_EN).
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- valid_in  in  1  instruction present in stage.
- mem_op_in  in  2  MEM_NONE / MEM_LOAD / MEM_STORE.
- funct3_in  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- alu_result_in  in  32  effective address, or rd value for non-memory ops.
- store_data_in  in  32  rs2 value for stores.
- rd_addr_in  in  5  destination register.
- writeback_en_in  in  1  instruction writes rd.
- rd_addr_out  out  5  to memory/writeback register.
- rd_out  out  32  ALU result or aligned/extended load data.
- writeback_en_out  out  1  qualified writeback enable.
- writeback_from_mem_out  out  1  rd_out came from memory.
- stall_out  out  1  freeze upstream stages and this stage's inputs.
- misaligned_out  out  1  one-cycle misaligned-access flag.
- bus_err_out  out  1  one-cycle timeout flag (tied 0 without MEM_TIMEOUT_EN).
- mem_req  out  1  data-bus request, registered.
- mem_we  out  1  store when 1.
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata  out  32  store data replicated per lane.
- mem_wstrb  out  4  byte enables.
- mem_rdata  in  32  load data, valid with mem_ack.
- mem_ack  in  1  transaction complete.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE, no memory op (or valid_in=0):
  - rd_out = alu_result_in; rd_addr_out = rd_addr_in.
  - writeback_en_out = valid_in & writeback_en_in.
  - writeback_from_mem_out=0; stall_out=0.
- IDLE, memory op, aligned:
  - Latch address, wdata, wstrb, funct3 and op.
  - stall_out=1; writeback_en_out=0; next state REQ.
- Misalignment: H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - misaligned_out=1 for that cycle; no bus request; writeback_en_out=0; no stall; state stays IDLE.
- REQ:
  - mem_req=1, stall_out=1, mem_we=(op==STORE).
  - Address, wdata and wstrb are held stable until ack.
  - On mem_ack, capture mem_rdata into hold register; next state RESP.
- RESP:
  - stall_out=0.
  - Loads: rd_out = lane-selected byte/half/word, sign- or zero-extended per funct3; writeback_from_mem_out=1; writeback_en_out=writeback_en_in.
  - Stores: writeback_en_out=0.
  - Next state IDLE.
- Store lanes:
  - SB: wdata = 4 copies of byte; wstrb = 1 << addr[1:0].
  - SH: wdata = 2 copies of half; wstrb = 0011 or 1100.
  - SW: wstrb = 1111.
- Reset (asynchronous, any state including REQ mid-transaction):
  - State IDLE; mem_req, stall_out, misaligned_out, bus_err_out, writeback_en_out, writeback_from_mem_out = 0.
  - rd_out, rd_addr_out, hold register = 0 while rst is high.
  - A late ack after reset is ignored.

## Timing
- Non-memory op: zero added latency (combinational pass-through).
- Memory op: mem_req rises on the edge after the IDLE decode. Ack may arrive in the first REQ cycle.
- Minimum memory instruction occupancy is 3 cycles (IDLE, REQ, RESP); each extra wait cycle adds 1.
- mem_ack outside REQ is ignored.

## Configuration
- MEM_TIMEOUT_EN defined:
  - An 8+ bit counter is cleared on entering REQ and increments each REQ cycle without ack.
  - When the count reaches TIMEOUT_CYCLES, mem_req drops, bus_err_out=1 for the RESP cycle, and writeback_en_out=0.
- MEM_TIMEOUT_EN undefined: no counter; REQ waits indefinitely; bus_err_out tied 0.

## Structure
- Package mem_pkg: mem_op_e enum, funct3 size constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), mem_state_e enum (IDLE/REQ/RESP).
- One sub-module, load_align: combinational lane select plus extension from (rdata, addr[1:0], funct3) to 32-bit rd value.

## Test plan
- ADD passthrough: alu_result_in=0x0000_1234, rd=5, wb_en=1 -> same cycle rd_out=0x1234, writeback_en_out=1, stall_out=0, mem_req never asserted.
- LB addr 0x103, rdata 0x80AA_BBCC, ack in first REQ cycle -> stall for 2 cycles; RESP rd_out=0xFFFF_FF80, writeback_from_mem_out=1; LBU same -> 0x0000_0080.
- SH addr 0x202, data 0x0000_BEEF, ack after 3 wait cycles -> mem_addr=0x200, wdata=0xBEEF_BEEF, wstrb=1100, mem_we=1 held stable; RESP writeback_en_out=0.
- LW addr 0x101 -> misaligned_out=1 one cycle, mem_req=0, writeback_en_out=0, stall_out=0.
- rst asserted in second REQ cycle -> mem_req and stall_out fall without a clock edge; ack next cycle causes no writeback.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> mem_req drops after 4 REQ cycles, bus_err_out=1 for one cycle, writeback_en_out=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-access stage: bus operation
// encoding, RV32I load/store size codes, FSM states and the store-lane
// formatting helpers used when a request is latched.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } mem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Halfwords must sit on an even address, words on a multiple of four.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    case (funct3)
      F3_H, F3_HU: return addr_lo[0];
      F3_W:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Replicate the store operand so every candidate lane carries it; the
  // byte enables then pick the lane the memory actually writes.
  function automatic logic [31:0] store_lanes(input logic [2:0]  funct3,
                                              input logic [31:0] data);
    case (funct3)
      F3_B:    return {4{data[7:0]}};
      F3_H:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  // Byte enables for the addressed lane(s) of the word.
  function automatic logic [3:0] store_strobes(input logic [2:0] funct3,
                                               input logic [1:0] addr_lo);
    case (funct3)
      F3_B:    return 4'b0001 << addr_lo;
      F3_H:    return addr_lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load data formatter: picks the addressed byte/halfword out of the
// returned bus word and sign- or zero-extends it to a 32-bit rd value.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] rd_value
);

  logic [31:0] shifted;

  // Shift the addressed lane down to bit 0, then extend by access size.
  always_comb begin
    shifted  = rdata >> {addr_lo, 3'b000};
    rd_value = shifted;
    case (funct3)
      F3_B:    rd_value = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   rd_value = {24'h000000, shifted[7:0]};
      F3_H:    rd_value = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   rd_value = {16'h0000, shifted[15:0]};
      default: rd_value = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage. Non-memory instructions pass straight
// through; loads and stores run one request/acknowledge transaction on the
// data bus while holding the upstream pipeline with stall_out.
// Optional feature macro: MEM_TIMEOUT_EN adds a REQ-state watchdog that
// aborts the access after TIMEOUT_CYCLES cycles without mem_ack and
// reports it on bus_err_out.
module mem_access
  import mem_pkg::*;
`ifdef MEM_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [1:0]  mem_op_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [4:0]  rd_addr_in,
  input  logic        writeback_en_in,
  output logic [4:0]  rd_addr_out,
  output logic [31:0] rd_out,
  output logic        writeback_en_out,
  output logic        writeback_from_mem_out,
  output logic        stall_out,
  output logic        misaligned_out,
  output logic        bus_err_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  mem_state_e  state_q;
  mem_state_e  state_d;
  mem_op_e     op_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;
  logic [31:0] load_value;
  logic        is_mem;
  logic        misaligned;
  logic        start;
  logic        timeout_hit;
  logic        resp_err;

  assign is_mem     = valid_in &&
                      ((mem_op_in == MEM_LOAD) || (mem_op_in == MEM_STORE));
  assign misaligned = is_misaligned(funct3_in, alu_result_in[1:0]);

  // The bus interface is driven purely from registers, so mem_req falls
  // the moment reset forces the state back to IDLE.
  assign mem_req   = (state_q == REQ);
  assign mem_we    = mem_req && (op_q == MEM_STORE);
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;

  load_align u_load_align (
    .rdata    (rdata_q),
    .addr_lo  (addr_q[1:0]),
    .funct3   (funct3_q),
    .rd_value (load_value)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                         $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] wait_cnt_q;
  logic             err_q;

  // The last unacknowledged REQ cycle is the one where the count is about
  // to reach TIMEOUT_CYCLES.
  assign timeout_hit = (state_q == REQ) && !mem_ack &&
                       (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign resp_err    = err_q;

  // Count unacknowledged REQ cycles and remember whether the access timed out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else if (start) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else if (state_q == REQ && !mem_ack) begin
      wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign resp_err    = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the request when it is accepted and capture read data on ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      funct3_q <= '0;
      op_q     <= MEM_NONE;
      rdata_q  <= '0;
    end else begin
      if (start) begin
        addr_q   <= alu_result_in;
        wdata_q  <= store_lanes(funct3_in, store_data_in);
        wstrb_q  <= store_strobes(funct3_in, alu_result_in[1:0]);
        funct3_q <= funct3_in;
        op_q     <= mem_op_e'(mem_op_in);
      end
      if (state_q == REQ && mem_ack) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  // Next-state decode plus all stage outputs; reset overrides everything
  // combinationally so the pipeline sees a clean stage without a clock.
  always_comb begin
    state_d                = state_q;
    start                  = 1'b0;
    rd_out                 = alu_result_in;
    rd_addr_out            = rd_addr_in;
    writeback_en_out       = 1'b0;
    writeback_from_mem_out = 1'b0;
    stall_out              = 1'b0;
    misaligned_out         = 1'b0;
    bus_err_out            = 1'b0;

    if (rst) begin
      state_d     = IDLE;
      rd_out      = '0;
      rd_addr_out = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_mem) begin
            if (misaligned) begin
              misaligned_out = 1'b1;
            end else begin
              start     = 1'b1;
              stall_out = 1'b1;
              state_d   = REQ;
            end
          end else begin
            writeback_en_out = valid_in & writeback_en_in;
          end
        end
        REQ: begin
          stall_out = 1'b1;
          if (mem_ack || timeout_hit) begin
            state_d = RESP;
          end
        end
        RESP: begin
          state_d     = IDLE;
          bus_err_out = resp_err;
          if (op_q == MEM_LOAD && !resp_err) begin
            rd_out                 = load_value;
            writeback_from_mem_out = 1'b1;
            writeback_en_out       = writeback_en_in;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios with literal
// expectations plus randomized instruction streams checked every cycle
// against a transaction-level model of the stage.
module tb_mem_access;
  import mem_pkg::*;

`ifdef MEM_TIMEOUT_EN
  localparam int MAX_WAIT = 2;
`else
  localparam int MAX_WAIT = 4;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [1:0]  mem_op_in;
  logic [2:0]  funct3_in;
  logic [31:0] alu_result_in;
  logic [31:0] store_data_in;
  logic [4:0]  rd_addr_in;
  logic        writeback_en_in;
  logic [4:0]  rd_addr_out;
  logic [31:0] rd_out;
  logic        writeback_en_out;
  logic        writeback_from_mem_out;
  logic        stall_out;
  logic        misaligned_out;
  logic        bus_err_out;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks   = 0;
  int failures = 0;

  logic        check_en = 1'b0;
  logic        chk_rd;
  logic [31:0] exp_rd;
  logic [4:0]  exp_rd_addr;
  logic        exp_wb, exp_from_mem, exp_stall, exp_mis, exp_err;
  logic        exp_req, exp_we;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_wstrb;

  logic [31:0] r_rd, r_addr, r_wdata;
  logic [3:0]  r_wstrb;
  bit          r_from_mem, r_wb, r_mis, r_req_seen, r_we;
  int          r_stall;

`ifdef MEM_TIMEOUT_EN
  mem_access #(.TIMEOUT_CYCLES(4)) dut (
`else
  mem_access dut (
`endif
    .clk                    (clk),
    .rst                    (rst),
    .valid_in               (valid_in),
    .mem_op_in              (mem_op_in),
    .funct3_in              (funct3_in),
    .alu_result_in          (alu_result_in),
    .store_data_in          (store_data_in),
    .rd_addr_in             (rd_addr_in),
    .writeback_en_in        (writeback_en_in),
    .rd_addr_out            (rd_addr_out),
    .rd_out                 (rd_out),
    .writeback_en_out       (writeback_en_out),
    .writeback_from_mem_out (writeback_from_mem_out),
    .stall_out              (stall_out),
    .misaligned_out         (misaligned_out),
    .bus_err_out            (bus_err_out),
    .mem_req                (mem_req),
    .mem_we                 (mem_we),
    .mem_addr               (mem_addr),
    .mem_wdata              (mem_wdata),
    .mem_wstrb              (mem_wstrb),
    .mem_rdata              (mem_rdata),
    .mem_ack                (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // ---- behavioural model: access size, lane rules, load extension ----
  function automatic int unsigned access_bytes(input logic [2:0] f3);
    return 32'd1 << f3[1:0];
  endfunction

  function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] a);
    return (a % access_bytes(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (access_bytes(f3))
      1:       return 32'(d[7:0]) * 32'h0101_0101;
      2:       return 32'(d[15:0]) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] model_wstrb(input logic [2:0] f3, input logic [31:0] a);
    logic [7:0] m;
    m = 8'((32'd1 << access_bytes(f3)) - 32'd1);
    m = m << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] a,
                                             input logic [2:0] f3);
    int unsigned n;
    logic [31:0] v, mask;
    n = access_bytes(f3);
    v = rdata >> (8 * (a % 4));
    if (n >= 4) return v;
    mask = 32'((64'd1 << (8 * n)) - 64'd1);
    v = v & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // ---- single compare process, every falling edge ----
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("stall_out", 32'(stall_out), 32'(exp_stall));
      checkOutput("writeback_en_out", 32'(writeback_en_out), 32'(exp_wb));
      checkOutput("writeback_from_mem_out", 32'(writeback_from_mem_out), 32'(exp_from_mem));
      checkOutput("misaligned_out", 32'(misaligned_out), 32'(exp_mis));
      checkOutput("bus_err_out", 32'(bus_err_out), 32'(exp_err));
      checkOutput("mem_req", 32'(mem_req), 32'(exp_req));
      checkOutput("rd_addr_out", 32'(rd_addr_out), 32'(exp_rd_addr));
      if (chk_rd) checkOutput("rd_out", rd_out, exp_rd);
      if (exp_req) begin
        checkOutput("mem_we", 32'(mem_we), 32'(exp_we));
        checkOutput("mem_addr", mem_addr, exp_addr);
        if (exp_we) begin
          checkOutput("mem_wdata", mem_wdata, exp_wdata);
          checkOutput("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setQuiet(input logic [31:0] alu, input logic [4:0] rd);
    chk_rd = 1'b1; exp_rd = alu; exp_rd_addr = rd;
    exp_wb = 1'b0; exp_from_mem = 1'b0; exp_stall = 1'b0;
    exp_mis = 1'b0; exp_err = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
  endtask

  task automatic sampleOutputs();
    #2;
    r_rd = rd_out; r_wb = writeback_en_out; r_from_mem = writeback_from_mem_out;
    r_mis = r_mis | misaligned_out; r_req_seen = r_req_seen | mem_req;
    if (stall_out) r_stall++;
    if (mem_req) begin
      r_addr = mem_addr; r_wdata = mem_wdata; r_wstrb = mem_wstrb; r_we = mem_we;
    end
  endtask

  // One instruction through the stage; upstream holds it while stalled.
  task automatic applyStimulus(input bit valid, input logic [1:0] op, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [4:0] rd, input bit wben, input int waits,
                               input logic [31:0] rdata, input bit stray);
    bit is_mem;
    is_mem = valid && (op == MEM_LOAD || op == MEM_STORE);
    r_mis = 0; r_req_seen = 0; r_stall = 0; r_we = 0;
    valid_in = valid; mem_op_in = op; funct3_in = f3; alu_result_in = addr;
    store_data_in = sdata; rd_addr_in = rd; writeback_en_in = wben;
    mem_ack = stray; mem_rdata = $urandom;
    setQuiet(addr, rd);
    if (!is_mem) begin
      exp_wb = valid & wben;
    end else if (model_misaligned(f3, addr)) begin
      chk_rd = 1'b0; exp_mis = 1'b1;
    end else begin
      chk_rd = 1'b0; exp_stall = 1'b1;
    end
    check_en = 1'b1;
    sampleOutputs();
    tick();
    if (is_mem && !model_misaligned(f3, addr)) begin
      for (int w = 0; w <= waits; w++) begin
        mem_ack   = (w == waits);
        mem_rdata = (w == waits) ? rdata : $urandom;
        setQuiet(addr, rd);
        chk_rd = 1'b0; exp_stall = 1'b1; exp_req = 1'b1;
        exp_we = (op == MEM_STORE); exp_addr = addr & 32'hFFFF_FFFC;
        exp_wdata = model_wdata(f3, sdata); exp_wstrb = model_wstrb(f3, addr);
        sampleOutputs();
        tick();
      end
      mem_ack = stray; mem_rdata = $urandom;
      setQuiet(addr, rd);
      if (op == MEM_LOAD) begin
        exp_rd = model_load(rdata, addr, f3); exp_from_mem = 1'b1; exp_wb = wben;
      end else begin
        chk_rd = 1'b0;
      end
      sampleOutputs();
      tick();
    end
  endtask

  initial begin
    logic [2:0] load_f3 [5];
    logic [2:0] f3;
    logic [1:0] op;
    logic [31:0] addr;
    int sel;
    load_f3 = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};

    // Reset: outputs cleared even with an instruction presented.
    rst = 1'b1; valid_in = 1'b1; mem_op_in = MEM_LOAD; funct3_in = F3_W;
    alu_result_in = 32'h0000_ABCC; store_data_in = '0; rd_addr_in = 5'd3;
    writeback_en_in = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    setQuiet(32'h0, 5'd0);
    check_en = 1'b1;
    #2;
    checkOutput("reset_rd_out", rd_out, 32'h0);
    checkOutput("reset_stall", 32'(stall_out), 32'h0);
    repeat (2) tick();
    rst = 1'b0;

    // ADD passthrough
    applyStimulus(1, MEM_NONE, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1, 0, 32'h0, 0);
    checkOutput("add_rd_out", r_rd, 32'h0000_1234);
    checkOutput("add_wb", 32'(r_wb), 32'h1);
    checkOutput("add_stall_cycles", 32'(r_stall), 32'h0);
    checkOutput("add_req_seen", 32'(r_req_seen), 32'h0);

    // LB / LBU from 0x103
    applyStimulus(1, MEM_LOAD, F3_B, 32'h0000_0103, 32'h0, 5'd6, 1, 0, 32'h80AA_BBCC, 0);
    checkOutput("lb_stall_cycles", 32'(r_stall), 32'h2);
    checkOutput("lb_rd_out", r_rd, 32'hFFFF_FF80);
    checkOutput("lb_from_mem", 32'(r_from_mem), 32'h1);
    applyStimulus(1, MEM_LOAD, F3_BU, 32'h0000_0103, 32'h0, 5'd6, 1, 0, 32'h80AA_BBCC, 0);
    checkOutput("lbu_rd_out", r_rd, 32'h0000_0080);

    // SH to 0x202 with three wait cycles
    applyStimulus(1, MEM_STORE, F3_H, 32'h0000_0202, 32'h0000_BEEF, 5'd9, 1,
                  (MAX_WAIT < 3) ? MAX_WAIT : 3, 32'h0, 0);
    checkOutput("sh_addr", r_addr, 32'h0000_0200);
    checkOutput("sh_wdata", r_wdata, 32'hBEEF_BEEF);
    checkOutput("sh_wstrb", 32'(r_wstrb), 32'hC);
    checkOutput("sh_we", 32'(r_we), 32'h1);
    checkOutput("sh_resp_wb", 32'(r_wb), 32'h0);

    // LW misaligned
    applyStimulus(1, MEM_LOAD, F3_W, 32'h0000_0101, 32'h0, 5'd4, 1, 0, 32'h0, 0);
    checkOutput("lw_mis_flag", 32'(r_mis), 32'h1);
    checkOutput("lw_mis_req", 32'(r_req_seen), 32'h0);
    checkOutput("lw_mis_wb", 32'(r_wb), 32'h0);
    checkOutput("lw_mis_stall", 32'(r_stall), 32'h0);

    // Reset in the second REQ cycle, then a late ack
    valid_in = 1; mem_op_in = MEM_LOAD; funct3_in = F3_W; alu_result_in = 32'h100;
    rd_addr_in = 5'd7; writeback_en_in = 1; mem_ack = 0;
    setQuiet(32'h100, 5'd7); chk_rd = 0; exp_stall = 1;
    tick();
    exp_req = 1; exp_addr = 32'h100;
    tick();
    rst = 1'b1;
    setQuiet(32'h0, 5'd0);
    #1;
    checkOutput("rst_async_req", 32'(mem_req), 32'h0);
    checkOutput("rst_async_stall", 32'(stall_out), 32'h0);
    tick();
    rst = 1'b0; valid_in = 0; mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
    setQuiet(32'h100, 5'd7);
    #2;
    checkOutput("late_ack_wb", 32'(writeback_en_out), 32'h0);
    tick();
    mem_ack = 0;
    tick();

`ifdef MEM_TIMEOUT_EN
    // No ack: abort after four REQ cycles
    valid_in = 1; mem_op_in = MEM_LOAD; funct3_in = F3_W; alu_result_in = 32'h300;
    rd_addr_in = 5'd8; writeback_en_in = 1; mem_ack = 0;
    setQuiet(32'h300, 5'd8); chk_rd = 0; exp_stall = 1;
    tick();
    for (int c = 0; c < 4; c++) begin
      exp_req = 1; exp_addr = 32'h300; exp_stall = 1;
      tick();
    end
    setQuiet(32'h300, 5'd8); chk_rd = 0; exp_err = 1;
    #2;
    checkOutput("timeout_bus_err", 32'(bus_err_out), 32'h1);
    tick();
    valid_in = 0;
    setQuiet(32'h300, 5'd8);
    tick();
`endif

    // Randomized instruction stream
    for (int i = 0; i < 200; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        op = MEM_NONE; f3 = 3'($urandom);
      end else if (sel < 7) begin
        op = MEM_LOAD; f3 = load_f3[$urandom_range(0, 4)];
      end else begin
        op = MEM_STORE; f3 = 3'($urandom_range(0, 2));
      end
      addr = $urandom;
      if ($urandom_range(0, 2) != 0) addr = addr - (addr % access_bytes(f3));
      applyStimulus($urandom_range(0, 9) != 0, op, f3, addr, $urandom, 5'($urandom),
                    1'($urandom), $urandom_range(0, MAX_WAIT), $urandom,
                    $urandom_range(0, 3) == 0);
    end

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
